// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the CNN feature path
// (feature_fwft, window generator, conv stages).
package cnn_pkg;

  localparam int DW = 8;

  typedef logic [DW-1:0] feature_t;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int K_DEF     = 3;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: dout is the pixel pushed exactly DEPTH shifts ago.
// Contents are never reset; the window generator masks stale data by position.
module line_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 28
) (
  input  logic          clk,
  input  logic          shift_en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [DEPTH-1:0][DW-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (shift_en) begin
      mem_d = {mem_q[DEPTH-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/feature_window_gen.sv
// Builds KxK valid-padding, stride-1 windows from a raster pixel stream
// popped from an FWFT FIFO; output is a registered valid/ready stream.
module feature_window_gen
  import cnn_pkg::*;
#(
  parameter int DW    = cnn_pkg::DW,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = K_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              feature_valid,
  input  logic [DW-1:0]     in_feature,
  output logic              rd_en,
  input  logic              win_ready,
  output logic              win_valid,
  output logic [K*K*DW-1:0] win_data,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [K*K-1:0][DW-1:0] win_q, win_d;

  // tap[m] is the pixel at the current column, m rows above the incoming one
  logic [DW-1:0] tap [K];

  logic consume;
  logic col_end;
  logic row_end;
  logic win_pos;

  assign rd_en   = rst & (~valid_q | win_ready);
  assign consume = rd_en & feature_valid;

  assign tap[0] = in_feature;

  for (genvar m = 0; m < K - 1; m++) begin : g_lb
    line_buffer #(
      .DW    (DW),
      .DEPTH (IMG_W)
    ) u_line_buffer (
      .clk      (clk),
      .shift_en (consume),
      .din      (tap[m]),
      .dout     (tap[m+1])
    );
  end

  assign col_end = (col_q == CW'(IMG_W - 1));
  assign row_end = (row_q == RW'(IMG_H - 1));
  assign win_pos = (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    done_d  = done_q;
    win_d   = win_q;

    if (valid_q && win_ready) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    // consume implies the held window (if any) is handed off this cycle
    if (consume) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[i*K+j] = win_q[i*K+j+1];
        end
        win_d[i*K+K-1] = tap[K-1-i];
      end

      valid_d = win_pos;
      done_d  = win_pos && row_end && col_end;

      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign win_valid  = valid_q;
  assign win_data   = win_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_feature_window_gen.sv
// Bench for feature_window_gen on a 5x4 image with a 3x3 kernel: image-array
// reference model plus fixed window tables for the named scenarios.
module tb_feature_window_gen;

  localparam int TW = 5;
  localparam int TH = 4;
  localparam int TK = 3;

  logic        clk;
  logic        rst;
  logic        feature_valid;
  logic [7:0]  in_feature;
  logic        rd_en;
  logic        win_ready;
  logic        win_valid;
  logic [71:0] win_data;
  logic        frame_done;

  feature_window_gen #(
    .DW    (8),
    .IMG_W (TW),
    .IMG_H (TH),
    .K     (TK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .feature_valid (feature_valid),
    .in_feature    (in_feature),
    .rd_en         (rd_en),
    .win_ready     (win_ready),
    .win_valid     (win_valid),
    .win_data      (win_data),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: the current frame as a 2-D image plus the pending window
  logic [7:0]  img [TH][TW];
  int          pr = 0;
  int          pc = 0;
  bit          exp_valid = 1'b0;
  bit          exp_done  = 1'b0;
  logic [71:0] exp_data  = '0;
  logic [7:0]  next_byte = 8'd0;
  bit          rand_data = 1'b0;

  logic [71:0] log_d [$];
  bit          log_f [$];

  typedef struct {
    logic [7:0] base;
    bit         done;
  } vec_t;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait budget expired at %0t", nm, $time);
  endtask

  // window whose top-left pixel is b, for a stream of consecutive bytes
  function automatic logic [71:0] mkwin(input logic [7:0] b);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < TK; i++)
      for (int j = 0; j < TK; j++)
        w[(i*TK+j)*8 +: 8] = b + 8'(i*TW + j);
    return w;
  endfunction

  // One clock: drive at negedge, check, advance model, return at next negedge.
  task automatic cycle(input bit fv, input bit wr, input bit rs);
    bit exp_rd;
    feature_valid = fv;
    win_ready     = wr;
    rst           = rs;
    in_feature    = next_byte;
    #1;
    exp_rd = rs && (!exp_valid || wr);
    chk("rd_en", rd_en, exp_rd);
    chk("win_valid", win_valid, exp_valid);
    chk("frame_done", frame_done, exp_done);
    if (exp_valid) chk("win_data", win_data, exp_data);
    if (rs && win_valid && wr) begin
      log_d.push_back(win_data);
      log_f.push_back(frame_done);
    end

    if (!rs) begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      pr = 0;
      pc = 0;
    end else begin
      if (exp_valid && wr) begin
        exp_valid = 1'b0;
        exp_done  = 1'b0;
      end
      if (exp_rd && fv) begin
        img[pr][pc] = next_byte;
        if (pr >= TK-1 && pc >= TK-1) begin
          for (int i = 0; i < TK; i++)
            for (int j = 0; j < TK; j++)
              exp_data[(i*TK+j)*8 +: 8] = img[pr-TK+1+i][pc-TK+1+j];
          exp_valid = 1'b1;
          exp_done  = (pr == TH-1) && (pc == TW-1);
        end
        pc++;
        if (pc == TW) begin
          pc = 0;
          pr = (pr == TH-1) ? 0 : pr + 1;
        end
        next_byte = rand_data ? 8'($urandom) : next_byte + 8'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic finish_frame(input string nm);
    int n;
    n = 0;
    while ((pr != 0 || pc != 0) && n < 40) begin
      cycle(1'b1, 1'b1, 1'b1);
      n++;
    end
    if (pr != 0 || pc != 0) fail_now(nm);
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [12];
    int          offs [6];
    logic [71:0] frozen;
    logic [7:0]  v;
    int          n;

    tbl[0]  = '{8'd0,  1'b0}; tbl[1]  = '{8'd1,  1'b0}; tbl[2]  = '{8'd2,  1'b0};
    tbl[3]  = '{8'd5,  1'b0}; tbl[4]  = '{8'd6,  1'b0}; tbl[5]  = '{8'd7,  1'b1};
    tbl[6]  = '{8'd20, 1'b0}; tbl[7]  = '{8'd21, 1'b0}; tbl[8]  = '{8'd22, 1'b0};
    tbl[9]  = '{8'd25, 1'b0}; tbl[10] = '{8'd26, 1'b0}; tbl[11] = '{8'd27, 1'b1};
    offs = '{0, 1, 2, 5, 6, 7};

    rst = 1'b0;
    feature_valid = 1'b0;
    win_ready = 1'b0;
    in_feature = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    chk("reset_win_data", win_data, 72'd0);
    chk("reset_frame_done", frame_done, 1'b0);

    // two frames of continuous input, compared against the window table
    next_byte = 8'd0;
    log_d.delete();
    log_f.delete();
    repeat (40) cycle(1'b1, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b1, 1'b1);
    chk("cont_window_count", 72'(log_d.size()), 72'd12);
    for (int k = 0; k < 12; k++) begin
      if (k < log_d.size()) begin
        chk($sformatf("cont_win%0d_data", k), log_d[k], mkwin(tbl[k].base));
        chk($sformatf("cont_win%0d_done", k), 72'(log_f[k]), 72'(tbl[k].done));
      end
    end

    // backpressure: hold the first window of frame 3 for five cycles
    n = 0;
    while (!exp_valid && n < 50) begin
      cycle(1'b1, 1'b1, 1'b1);
      n++;
    end
    if (!exp_valid) fail_now("bp_first_window");
    chk("bp_first_data", win_data, mkwin(8'd40));
    frozen = win_data;
    repeat (5) begin
      cycle(1'b1, 1'b0, 1'b1);
      chk("bp_frozen_data", win_data, frozen);
      chk("bp_frozen_valid", win_valid, 1'b1);
    end
    cycle(1'b1, 1'b1, 1'b1);
    chk("bp_next_valid", win_valid, 1'b1);
    chk("bp_next_data", win_data, mkwin(8'd41));
    finish_frame("bp_finish_frame");

    // input starvation: 10 cycles on, 5 off, for one whole frame
    v = next_byte;
    log_d.delete();
    log_f.delete();
    n = 0;
    while (next_byte != v + 8'd20 && n < 200) begin
      cycle((n % 15) < 10, 1'b1, 1'b1);
      n++;
    end
    if (next_byte != v + 8'd20) fail_now("starve_frame");
    cycle(1'b0, 1'b1, 1'b1);
    chk("starve_window_count", 72'(log_d.size()), 72'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < log_d.size()) begin
        chk($sformatf("starve_win%0d_data", k), log_d[k], mkwin(v + 8'(offs[k])));
        chk($sformatf("starve_win%0d_done", k), 72'(log_f[k]), 72'(k == 5));
      end
    end

    // reset after pixel 8 of a frame; next pixel restarts at (0,0)
    repeat (9) cycle(1'b1, 1'b1, 1'b1);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    v = next_byte;
    log_d.delete();
    log_f.delete();
    repeat (13) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("rstmid_window_count", 72'(log_d.size()), 72'd1);
    if (log_d.size() > 0) chk("rstmid_first_data", log_d[0], mkwin(v));
    finish_frame("rstmid_finish_frame");

    // byte wrap across 0xFF -> 0x00
    next_byte = 8'hFD;
    log_d.delete();
    log_f.delete();
    repeat (20) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("wrap_window_count", 72'(log_d.size()), 72'd6);
    if (log_d.size() > 0) chk("wrap_first_data", log_d[0], 72'h09_08_07_04_03_02_FF_FE_FD);
    if (log_d.size() > 5) begin
      chk("wrap_last_data", log_d[5], mkwin(8'h04));
      chk("wrap_last_done", 72'(log_f[5]), 72'd1);
    end

    // random traffic, random data, occasional reset
    rand_data = 1'b1;
    next_byte = 8'($urandom);
    repeat (3000)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 299) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
